// File: rtl/aes_pkg.sv
// Shared AES-128 sequencer constants: FSM encoding, widths, round-constant seed and GF(2^8) doubling.
// No logic of its own; no latency and no backpressure.
// Imported by aes_round_ctrl and its state-select mux.
package aes_pkg;

  localparam int AES_DW = 128;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ROUND = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RCON_POLY = 8'h1B;

  // Multiply by x in GF(2^8) modulo the AES polynomial; steps rcon from round to round.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_round_ctrl_sel.sv
// 2:1 selector for the state-register input: a1 when s=0, a2 when s=1.
// Purely combinational, zero latency.
// No flow control.
module aes_round_ctrl_sel
  import aes_pkg::*;
#(
  parameter int W = AES_DW
) (
  input  logic [W-1:0] a1,
  input  logic [W-1:0] a2,
  input  logic         s,
  output logic [W-1:0] y
);

  assign y = s ? a2 : a1;

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 sequencer: initial AddRoundKey, ROUNDS passes through an external round datapath, then ciphertext.
// Latency: accept in cycle T, out_valid in cycle T+ROUNDS+1; one block per ROUNDS+2 cycles at best.
// Backpressure: ciphertext held until out_ready, no input accepted meanwhile; AES_ROUND_CTRL_ABORT_EN adds an abort input.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int DW     = AES_DW,
  parameter int ROUNDS = 10
) (
  input  logic          clk,
  input  logic          rst,
`ifdef AES_ROUND_CTRL_ABORT_EN
  input  logic          abort,
`endif
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] plaintext,
  input  logic [DW-1:0] key,
  output logic [DW-1:0] round_state,
  output logic [DW-1:0] round_key,
  output logic [7:0]    rcon,
  output logic          final_round,
  input  logic [DW-1:0] round_result,
  input  logic [DW-1:0] next_key,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] ciphertext
);

  localparam logic [3:0] CNT_LAST = 4'(ROUNDS);

  logic [1:0]    st;
  logic [1:0]    st_nxt;
  logic [DW-1:0] state_reg;
  logic [DW-1:0] key_reg;
  logic [7:0]    rcon_reg;
  logic [3:0]    cnt;
  logic [DW-1:0] state_d;
  logic          load;
  logic          last;
  logic          abort_act;

`ifdef AES_ROUND_CTRL_ABORT_EN
  assign abort_act = abort && (st != ST_IDLE);
`else
  assign abort_act = 1'b0;
`endif

  assign load = (st == ST_IDLE) && in_valid;
  assign last = (cnt == CNT_LAST);

  aes_round_ctrl_sel #(.W(DW)) u_state_sel (
    .a1 (plaintext ^ key),
    .a2 (round_result),
    .s  (st == ST_ROUND),
    .y  (state_d)
  );

  always_ff @(posedge clk) begin
    if (rst) st <= ST_IDLE;
    else     st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      ST_IDLE:  if (in_valid)  st_nxt = ST_ROUND;
      ST_ROUND: if (last)      st_nxt = ST_DONE;
      ST_DONE:  if (out_ready) st_nxt = ST_IDLE;
      default:                 st_nxt = ST_IDLE;
    endcase
    if (abort_act) st_nxt = ST_IDLE;
  end

  always_comb begin
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    final_round = 1'b0;
    case (st)
      ST_IDLE:  in_ready    = 1'b1;
      ST_ROUND: final_round = last;
      ST_DONE:  out_valid   = 1'b1;
      default:  ;
    endcase
  end

  // Abort wipes key material along with the state, not just the FSM.
  always_ff @(posedge clk) begin
    if (rst || abort_act) begin
      state_reg <= '0;
      key_reg   <= '0;
      rcon_reg  <= RCON_INIT;
      cnt       <= 4'd1;
    end else if (load) begin
      state_reg <= state_d;
      key_reg   <= key;
      rcon_reg  <= RCON_INIT;
      cnt       <= 4'd1;
    end else if (st == ST_ROUND) begin
      state_reg <= state_d;
      key_reg   <= next_key;
      rcon_reg  <= xtime(rcon_reg);
      cnt       <= cnt + 4'd1;
    end
  end

  assign round_state = state_reg;
  assign round_key   = key_reg;
  assign rcon        = rcon_reg;
  assign ciphertext  = state_reg;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl with an independent AES-128 round and key-expansion model as the datapath.
// Checks FIPS-197 vectors, rcon trace, latency, backpressure, mid-run reset, back-to-back and optional abort.
module tb_aes_round_ctrl;

  localparam logic [127:0] PT_A = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KY_A = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_A = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] X0_A = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [127:0] PT_B = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic [127:0] round_state;
  logic [127:0] round_key;
  logic [7:0]   rcon;
  logic         final_round;
  logic [127:0] round_result;
  logic [127:0] next_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ciphertext;
`ifdef AES_ROUND_CTRL_ABORT_EN
  logic         abort;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int n;
  int c1;
  int c2;
  logic [7:0] exp_rcon [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_round_ctrl #(.DW(128), .ROUNDS(10)) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef AES_ROUND_CTRL_ABORT_EN
    .abort        (abort),
`endif
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .plaintext    (plaintext),
    .key          (key),
    .round_state  (round_state),
    .round_key    (round_key),
    .rcon         (rcon),
    .final_round  (final_round),
    .round_result (round_result),
    .next_key     (next_key),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .ciphertext   (ciphertext)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from first principles: x^254 is the field inverse, then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = x;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] keyexp(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, rot, tmp;
    w0  = k[127:96];
    w1  = k[95:64];
    w2  = k[63:32];
    w3  = k[31:0];
    rot = {w3[23:0], w3[31:24]};
    tmp = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])} ^ {rc, 24'h0};
    w0  = w0 ^ tmp;
    w1  = w1 ^ w0;
    w2  = w2 ^ w1;
    w3  = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] rk,
                                             input logic fin);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int i = 0; i < 16; i++) s[i] = sbox(st[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[r+4*c] = s[r+4*((c+r)%4)];
    for (int c = 0; c < 4; c++) begin
      a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
      if (!fin) begin
        t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
        t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
        t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
        t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    return o ^ rk;
  endfunction

  assign next_key     = keyexp(round_key, rcon);
  assign round_result = aes_round(round_state, next_key, final_round);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Ticks until out_valid, bounded; cnt returns the ticks taken (40 means it never came).
  task automatic wait_ov(output int cnt);
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < 40) begin
      tick();
      cnt++;
    end
  endtask

  task automatic run_block(input logic [127:0] p, input logic [127:0] k,
                           input logic [127:0] ct, input string tag);
    int t;
    plaintext = p;
    key       = k;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    wait_ov(t);
    chk({tag, "_latency"}, 128'(t), 128'd10);
    chk({tag, "_ct"}, ciphertext, ct);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chkb({tag, "_idle_in_ready"}, in_ready, 1'b1);
    chkb({tag, "_idle_out_valid"}, out_valid, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    plaintext = '0;
    key       = '0;
`ifdef AES_ROUND_CTRL_ABORT_EN
    abort     = 1'b0;
`endif
    repeat (2) tick();
    rst = 1'b0;

    chkb("rst_in_ready", in_ready, 1'b1);
    chkb("rst_out_valid", out_valid, 1'b0);
    chkb("rst_final_round", final_round, 1'b0);
    chk("rst_round_state", round_state, '0);
    chk("rst_round_key", round_key, '0);
    chk("rst_ciphertext", ciphertext, '0);
    chk("rst_rcon", 128'(rcon), 128'h01);

    // FIPS-197 C.1 with a per-round rcon and final_round trace
    plaintext = PT_A;
    key       = KY_A;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    chk("ark0_state", round_state, X0_A);
    chk("ark0_key", round_key, KY_A);
    chkb("round_in_ready", in_ready, 1'b0);
    for (int k = 0; k < 10; k++) begin
      chk("rcon_trace", 128'(rcon), 128'(exp_rcon[k]));
      chkb("final_round", final_round, (k == 9));
      chkb("round_out_valid", out_valid, 1'b0);
      tick();
    end
    chkb("done_out_valid", out_valid, 1'b1);
    chk("fips_c1_ct", ciphertext, CT_A);

    // Backpressure: 20 stalled cycles, with a stray in_valid pulse in the middle
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        plaintext = PT_B;
        key       = KY_B;
        in_valid  = 1'b1;
      end else begin
        in_valid  = 1'b0;
      end
      chk("stall_ct_stable", ciphertext, CT_A);
      chkb("stall_out_valid", out_valid, 1'b1);
      chkb("stall_in_ready", in_ready, 1'b0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chkb("release_out_valid", out_valid, 1'b0);
    chkb("release_in_ready", in_ready, 1'b1);
    chk("stray_input_ignored", round_state, CT_A);

    // Reset in round 5 discards the block
    plaintext = PT_A;
    key       = KY_A;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    chk("accept_rcon_back_to_01", 128'(rcon), 128'h01);
    repeat (4) tick();
    chk("round5_rcon", 128'(rcon), 128'h10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chkb("midrst_in_ready", in_ready, 1'b1);
    chkb("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_round_state", round_state, '0);
    chk("midrst_round_key", round_key, '0);
    chk("midrst_rcon", 128'(rcon), 128'h01);
    repeat (12) begin
      chkb("midrst_no_out_valid", out_valid, 1'b0);
      tick();
    end
    run_block(PT_A, KY_A, CT_A, "post_rst");
    run_block(PT_B, KY_B, CT_B, "fips_b");

    // Back-to-back with in_valid held and out_ready high; inputs changed after the first accept
    plaintext = PT_A;
    key       = KY_A;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    plaintext = PT_B;
    key       = KY_B;
    wait_ov(n);
    c1 = cyc;
    chk("b2b_first_latency", 128'(n), 128'd10);
    chk("b2b_first_ct", ciphertext, CT_A);
    tick();
    chkb("b2b_idle_accepts", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    wait_ov(n);
    c2 = cyc;
    chk("b2b_spacing", 128'(c2 - c1), 128'd12);
    chk("b2b_second_ct", ciphertext, CT_B);
    tick();
    out_ready = 1'b0;
    chkb("b2b_end_out_valid", out_valid, 1'b0);

`ifdef AES_ROUND_CTRL_ABORT_EN
    // Abort in round 3 wipes state and key
    plaintext = PT_A;
    key       = KY_A;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    repeat (2) tick();
    chk("abort_round3_rcon", 128'(rcon), 128'h04);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chkb("abort_in_ready", in_ready, 1'b1);
    chkb("abort_out_valid", out_valid, 1'b0);
    chk("abort_round_state", round_state, '0);
    chk("abort_round_key", round_key, '0);
    repeat (12) begin
      chkb("abort_no_out_valid", out_valid, 1'b0);
      tick();
    end

    // Abort together with reset
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    abort = 1'b1;
    rst   = 1'b1;
    tick();
    abort = 1'b0;
    rst   = 1'b0;
    chkb("abort_rst_in_ready", in_ready, 1'b1);
    chk("abort_rst_rcon", 128'(rcon), 128'h01);
    chk("abort_rst_round_state", round_state, '0);
    chk("abort_rst_round_key", round_key, '0);

    // Abort in IDLE has no effect on an accept
    abort    = 1'b1;
    in_valid = 1'b1;
    tick();
    abort    = 1'b0;
    in_valid = 1'b0;
    chkb("abort_idle_accepted", in_ready, 1'b0);
    wait_ov(n);
    chk("abort_idle_ct", ciphertext, CT_A);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
